// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, ALUOp encodings and the control bundle
// carried from the main decoder into the EX stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memtowrite;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;

  // True for opcodes that read rt as a source operand.
  function automatic logic op_uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

  // An invalid ID slot contributes no control, whatever the decoder emitted.
  function automatic ctrl_t mask_ctrl(input ctrl_t c, input logic valid);
    return valid ? c : '0;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination
// register is read by the instruction currently in ID.
module load_use_detect
  import mips_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [5:0]        id_op,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              haz
);

  logic uses_rt;
  logic rs_match;
  logic rt_match;

  always_comb begin
    uses_rt  = op_uses_rt(id_op);
    rs_match = (ex_rt == id_rs);
    rt_match = uses_rt && (ex_rt == id_rt);
    // r0 is hardwired to zero, so a load targeting it never forwards anything
    haz = ex_valid && ex_memread && (ex_rt != '0) && id_valid && (rs_match || rt_match);
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall generation, branch flush,
// downstream hold and a saturating count of inserted hazard bubbles.
module id_ex_stage_reg
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [5:0]        id_op,
  input  logic              id_regdst,
  input  logic              id_alusrc,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memtowrite,
  input  logic              id_branch,
  input  logic [1:0]        id_aluop,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [5:0]        id_funct,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              ex_valid,
  output logic              ex_regdst,
  output logic              ex_alusrc,
  output logic              ex_memtoreg,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memtowrite,
  output logic              ex_branch,
  output logic [1:0]        ex_aluop,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [5:0]        ex_funct,
  output logic              stall_o,
  output logic [CNT_W-1:0]  bubble_cnt
);

  ctrl_t             id_ctrl;
  logic              haz;

  logic              valid_reg,  valid_next;
  ctrl_t             ctrl_reg,   ctrl_next;
  logic [DATA_W-1:0] pc4_reg,    pc4_next;
  logic [DATA_W-1:0] rdata1_reg, rdata1_next;
  logic [DATA_W-1:0] rdata2_reg, rdata2_next;
  logic [DATA_W-1:0] imm_reg,    imm_next;
  logic [REG_AW-1:0] rs_reg,     rs_next;
  logic [REG_AW-1:0] rt_reg,     rt_next;
  logic [REG_AW-1:0] rd_reg,     rd_next;
  logic [5:0]        funct_reg,  funct_next;
  logic [CNT_W-1:0]  cnt_reg,    cnt_next;

  always_comb begin
    id_ctrl = mask_ctrl('{regdst:     id_regdst,
                          alusrc:     id_alusrc,
                          memtoreg:   id_memtoreg,
                          regwrite:   id_regwrite,
                          memread:    id_memread,
                          memtowrite: id_memtowrite,
                          branch:     id_branch,
                          aluop:      id_aluop}, id_valid);
  end

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .ex_valid   (valid_reg),
    .ex_memread (ctrl_reg.memread),
    .ex_rt      (rt_reg),
    .id_valid   (id_valid),
    .id_op      (id_op),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .haz        (haz)
  );

  // A flush already kills the younger instruction, so stalling it would be redundant
  assign stall_o = haz && !flush_i;

  always_comb begin
    valid_next  = valid_reg;
    ctrl_next   = ctrl_reg;
    pc4_next    = pc4_reg;
    rdata1_next = rdata1_reg;
    rdata2_next = rdata2_reg;
    imm_next    = imm_reg;
    rs_next     = rs_reg;
    rt_next     = rt_reg;
    rd_next     = rd_reg;
    funct_next  = funct_reg;
    cnt_next    = cnt_reg;

    if (flush_i || (!hold_i && haz)) begin
      valid_next  = 1'b0;
      ctrl_next   = '0;
      pc4_next    = '0;
      rdata1_next = '0;
      rdata2_next = '0;
      imm_next    = '0;
      rs_next     = '0;
      rt_next     = '0;
      rd_next     = '0;
      funct_next  = '0;
      // Only hazard bubbles are counted; flush bubbles are a branch cost
      if (!flush_i && !(&cnt_reg)) begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end else if (!hold_i) begin
      valid_next  = id_valid;
      ctrl_next   = id_ctrl;
      pc4_next    = id_pc4;
      rdata1_next = id_rdata1;
      rdata2_next = id_rdata2;
      imm_next    = id_imm;
      rs_next     = id_rs;
      rt_next     = id_rt;
      rd_next     = id_rd;
      funct_next  = id_funct;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg  <= 1'b0;
      ctrl_reg   <= '0;
      pc4_reg    <= '0;
      rdata1_reg <= '0;
      rdata2_reg <= '0;
      imm_reg    <= '0;
      rs_reg     <= '0;
      rt_reg     <= '0;
      rd_reg     <= '0;
      funct_reg  <= '0;
      cnt_reg    <= '0;
    end else begin
      valid_reg  <= valid_next;
      ctrl_reg   <= ctrl_next;
      pc4_reg    <= pc4_next;
      rdata1_reg <= rdata1_next;
      rdata2_reg <= rdata2_next;
      imm_reg    <= imm_next;
      rs_reg     <= rs_next;
      rt_reg     <= rt_next;
      rd_reg     <= rd_next;
      funct_reg  <= funct_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign ex_valid      = valid_reg;
  assign ex_regdst     = ctrl_reg.regdst;
  assign ex_alusrc     = ctrl_reg.alusrc;
  assign ex_memtoreg   = ctrl_reg.memtoreg;
  assign ex_regwrite   = ctrl_reg.regwrite;
  assign ex_memread    = ctrl_reg.memread;
  assign ex_memtowrite = ctrl_reg.memtowrite;
  assign ex_branch     = ctrl_reg.branch;
  assign ex_aluop      = ctrl_reg.aluop;
  assign ex_pc4        = pc4_reg;
  assign ex_rdata1     = rdata1_reg;
  assign ex_rdata2     = rdata2_reg;
  assign ex_imm        = imm_reg;
  assign ex_rs         = rs_reg;
  assign ex_rt         = rt_reg;
  assign ex_rd         = rd_reg;
  assign ex_funct      = funct_reg;
  assign bubble_cnt    = cnt_reg;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: a default-width and a 2-bit-counter instance
// share stimulus and are both checked every cycle against a rule-level model.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [5:0]  id_op;
  logic [8:0]  id_ctrl_v;  // {regdst,alusrc,memtoreg,regwrite,memread,memtowrite,branch,aluop[1:0]}
  logic [31:0] id_pc4, id_rdata1, id_rdata2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic        flush_i, hold_i;

  logic        a_valid, a_regdst, a_alusrc, a_memtoreg, a_regwrite, a_memread, a_memtowrite, a_branch;
  logic [1:0]  a_aluop;
  logic [31:0] a_pc4, a_rdata1, a_rdata2, a_imm;
  logic [4:0]  a_rs, a_rt, a_rd;
  logic [5:0]  a_funct;
  logic        a_stall;
  logic [15:0] a_cnt;

  logic        b_valid, b_regdst, b_alusrc, b_memtoreg, b_regwrite, b_memread, b_memtowrite, b_branch;
  logic [1:0]  b_aluop;
  logic [31:0] b_pc4, b_rdata1, b_rdata2, b_imm;
  logic [4:0]  b_rs, b_rt, b_rd;
  logic [5:0]  b_funct;
  logic        b_stall;
  logic [1:0]  b_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op),
    .id_regdst(id_ctrl_v[8]), .id_alusrc(id_ctrl_v[7]), .id_memtoreg(id_ctrl_v[6]),
    .id_regwrite(id_ctrl_v[5]), .id_memread(id_ctrl_v[4]), .id_memtowrite(id_ctrl_v[3]),
    .id_branch(id_ctrl_v[2]), .id_aluop(id_ctrl_v[1:0]),
    .id_pc4(id_pc4), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
    .flush_i(flush_i), .hold_i(hold_i),
    .ex_valid(a_valid), .ex_regdst(a_regdst), .ex_alusrc(a_alusrc), .ex_memtoreg(a_memtoreg),
    .ex_regwrite(a_regwrite), .ex_memread(a_memread), .ex_memtowrite(a_memtowrite),
    .ex_branch(a_branch), .ex_aluop(a_aluop), .ex_pc4(a_pc4), .ex_rdata1(a_rdata1),
    .ex_rdata2(a_rdata2), .ex_imm(a_imm), .ex_rs(a_rs), .ex_rt(a_rt), .ex_rd(a_rd),
    .ex_funct(a_funct), .stall_o(a_stall), .bubble_cnt(a_cnt)
  );

  id_ex_stage_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op),
    .id_regdst(id_ctrl_v[8]), .id_alusrc(id_ctrl_v[7]), .id_memtoreg(id_ctrl_v[6]),
    .id_regwrite(id_ctrl_v[5]), .id_memread(id_ctrl_v[4]), .id_memtowrite(id_ctrl_v[3]),
    .id_branch(id_ctrl_v[2]), .id_aluop(id_ctrl_v[1:0]),
    .id_pc4(id_pc4), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
    .flush_i(flush_i), .hold_i(hold_i),
    .ex_valid(b_valid), .ex_regdst(b_regdst), .ex_alusrc(b_alusrc), .ex_memtoreg(b_memtoreg),
    .ex_regwrite(b_regwrite), .ex_memread(b_memread), .ex_memtowrite(b_memtowrite),
    .ex_branch(b_branch), .ex_aluop(b_aluop), .ex_pc4(b_pc4), .ex_rdata1(b_rdata1),
    .ex_rdata2(b_rdata2), .ex_imm(b_imm), .ex_rs(b_rs), .ex_rt(b_rt), .ex_rd(b_rd),
    .ex_funct(b_funct), .stall_o(b_stall), .bubble_cnt(b_cnt)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        valid;
    logic [8:0]  ctrl;
    logic [31:0] pc4, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
  } ex_t;

  ex_t m_ex;
  int  m_cnt16;
  int  m_cnt2;

  function automatic bit model_haz();
    bit reads_rt;
    bit ex_is_load;
    reads_rt   = (id_op == 6'b000000) || (id_op == 6'b101011) || (id_op == 6'b000100);
    ex_is_load = m_ex.valid && m_ex.ctrl[4];
    return ex_is_load && (m_ex.rt != 0) && id_valid &&
           ((m_ex.rt == id_rs) || (reads_rt && (m_ex.rt == id_rt)));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex    <= '0;
      m_cnt16 <= 0;
      m_cnt2  <= 0;
    end else if (flush_i) begin
      m_ex <= '0;
    end else if (hold_i) begin
      m_ex <= m_ex;
    end else if (model_haz()) begin
      m_ex    <= '0;
      m_cnt16 <= (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
      m_cnt2  <= (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
    end else begin
      m_ex <= '{valid: id_valid, ctrl: (id_valid ? id_ctrl_v : 9'd0),
                pc4: id_pc4, rd1: id_rdata1, rd2: id_rdata2, imm: id_imm,
                rs: id_rs, rt: id_rt, rd: id_rd, funct: id_funct};
    end
  end

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  ex_t a_vec, b_vec;
  assign a_vec = '{valid: a_valid, ctrl: {a_regdst, a_alusrc, a_memtoreg, a_regwrite, a_memread,
                   a_memtowrite, a_branch, a_aluop}, pc4: a_pc4, rd1: a_rdata1, rd2: a_rdata2,
                   imm: a_imm, rs: a_rs, rt: a_rt, rd: a_rd, funct: a_funct};
  assign b_vec = '{valid: b_valid, ctrl: {b_regdst, b_alusrc, b_memtoreg, b_regwrite, b_memread,
                   b_memtowrite, b_branch, b_aluop}, pc4: b_pc4, rd1: b_rdata1, rd2: b_rdata2,
                   imm: b_imm, rs: b_rs, rt: b_rt, rd: b_rd, funct: b_funct};

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    #2;
    chk("ex_fields_w16", a_vec, m_ex);
    chk("ex_fields_w2",  b_vec, m_ex);
    chk("stall_w16", a_stall, model_haz() && !flush_i);
    chk("stall_w2",  b_stall, model_haz() && !flush_i);
    chk("cnt_w16", a_cnt, m_cnt16[15:0]);
    chk("cnt_w2",  b_cnt, m_cnt2[1:0]);
  end

  // ---------------- stimulus ----------------
  int pc = 32'h0040_0000;

  task automatic next();
    @(negedge clk);
  endtask

  task automatic set_instr(input bit v, input bit [5:0] op, input bit [4:0] rs, input bit [4:0] rt,
                           input bit [4:0] rd, input bit [31:0] d1, input bit [31:0] d2);
    pc        = pc + 4;
    id_valid  = v;
    id_op     = op;
    case (op)
      6'b000000: id_ctrl_v = 9'b1_0_0_1_0_0_0_10;
      6'b100011: id_ctrl_v = 9'b0_1_1_1_1_0_0_00;
      6'b101011: id_ctrl_v = 9'b0_1_0_0_0_1_0_00;
      6'b000100: id_ctrl_v = 9'b0_0_0_0_0_0_1_01;
      default:   id_ctrl_v = 9'b1_1_1_1_1_1_1_11;
    endcase
    id_pc4    = pc;
    id_rdata1 = d1;
    id_rdata2 = d2;
    id_imm    = {27'h7FF_FFFF, rd};
    id_rs     = rs;
    id_rt     = rt;
    id_rd     = rd;
    id_funct  = {1'b1, rd};
    $display("t=%0t ID v=%0d op=%b rs=%0d rt=%0d rd=%0d flush=%0d hold=%0d",
             $time, v, op, rs, rt, rd, flush_i, hold_i);
  endtask

  initial begin
    rst_n   = 1'b0;
    flush_i = 1'b0;
    hold_i  = 1'b0;
    set_instr(0, 6'b000000, 0, 0, 0, 0, 0);
    repeat (2) next();
    #3;
    chk("reset_valid", a_valid, 1'b0);
    chk("reset_cnt", a_cnt, 16'd0);

    next(); rst_n = 1'b1;
    set_instr(1, 6'b000000, 1, 2, 3, 32'h11, 32'h22);           // add r3,r1,r2
    next(); set_instr(1, 6'b100011, 1, 8, 0, 32'h100, 32'h200); // lw r8
    #3;
    chk("rtype_regwrite", a_regwrite, 1'b1);
    chk("rtype_regdst", a_regdst, 1'b1);
    chk("rtype_rdata1", a_rdata1, 32'h11);
    chk("rtype_rd", a_rd, 5'd3);
    chk("rtype_valid", a_valid, 1'b1);
    chk("rtype_aluop", a_aluop, 2'b10);
    chk("rtype_stall", a_stall, 1'b0);

    next(); set_instr(1, 6'b000000, 8, 2, 4, 32'h33, 32'h44);   // add using r8
    #3;
    chk("lu_ex_memread", a_memread, 1'b1);
    chk("lu_ex_rt", a_rt, 5'd8);
    chk("lu_stall", a_stall, 1'b1);
    next(); #3;                                                 // bubble in EX
    chk("lu_bubble_valid", a_valid, 1'b0);
    chk("lu_bubble_memread", a_memread, 1'b0);
    chk("lu_cnt", a_cnt, 16'd1);
    chk("lu_cnt_w2", b_cnt, 2'd1);
    chk("lu_stall_drop", a_stall, 1'b0);
    next(); set_instr(1, 6'b100011, 9, 8, 0, 32'h1, 32'h2);     // lw r8 (EX now has add)
    #3;
    chk("lu_add_valid", a_valid, 1'b1);
    chk("lu_add_rs", a_rs, 5'd8);
    chk("lu_add_rd", a_rd, 5'd4);

    next(); set_instr(1, 6'b100011, 9, 8, 0, 32'h3, 32'h4);     // lw rt=8 vs lw rs=9 rt=8
    #3; chk("nofalse_lw_rt", a_stall, 1'b0);
    next(); set_instr(1, 6'b101011, 1, 8, 0, 32'h5, 32'h6);     // sw reads rt=8
    #3; chk("sw_rt_stall", a_stall, 1'b1);
    next(); next(); set_instr(1, 6'b100011, 1, 7, 0, 32'h7, 32'h8);
    next(); set_instr(1, 6'b000100, 1, 7, 0, 32'h9, 32'hA);     // beq reads rt=7
    #3; chk("beq_rt_stall", a_stall, 1'b1);
    next(); next(); set_instr(1, 6'b100011, 1, 0, 0, 32'hB, 32'hC);
    next(); set_instr(1, 6'b000000, 0, 0, 5, 32'hD, 32'hE);     // r0 never hazards
    #3; chk("nofalse_r0", a_stall, 1'b0);

    next(); set_instr(1, 6'b100011, 1, 8, 0, 32'hF, 32'h10);
    next(); set_instr(1, 6'b000000, 8, 3, 6, 32'h12, 32'h13); flush_i = 1'b1;
    #3; chk("flush_stall", a_stall, 1'b0);
    next(); flush_i = 1'b0;
    #3;
    chk("flush_bubble", a_valid, 1'b0);
    chk("flush_cnt", a_cnt, 16'd3);

    next(); set_instr(1, 6'b100011, 2, 5, 0, 32'h55, 32'h66);
    next(); set_instr(1, 6'b000000, 5, 1, 7, 32'h77, 32'h88); hold_i = 1'b1;
    #3; chk("hold_stall", a_stall, 1'b1);
    for (int i = 0; i < 3; i++) begin
      next(); id_rdata2 = $urandom;
      #3;
      chk("hold_rdata1", a_rdata1, 32'h55);
      chk("hold_memread", a_memread, 1'b1);
      chk("hold_cnt", a_cnt, 16'd3);
      chk("hold_stall_live", a_stall, 1'b1);
    end
    hold_i = 1'b0;
    next(); #3; chk("after_hold_cnt", a_cnt, 16'd4);
    next();

    for (int i = 0; i < 5; i++) begin
      next(); set_instr(1, 6'b100011, 1, 9, 0, i, i + 1);
      next(); set_instr(1, 6'b000000, 9, 2, 3, i + 2, i + 3);
      next();
    end
    next(); #3;
    chk("sat_cnt_w2", b_cnt, 2'd3);
    chk("cnt_w16_total", a_cnt, 16'd9);

    set_instr(0, 6'b111111, 1, 2, 3, 32'hAA, 32'hBB);           // undecoded, invalid
    next(); #3;
    chk("inv_valid", a_valid, 1'b0);
    chk("inv_regwrite", a_regwrite, 1'b0);
    chk("inv_memread", a_memread, 1'b0);

    next(); set_instr(1, 6'b100011, 1, 8, 0, 32'h1, 32'h2);
    next(); set_instr(1, 6'b000000, 8, 2, 4, 32'h3, 32'h4);
    #1; chk("pre_reset_stall", a_stall, 1'b1);
    #2; rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", a_valid, 1'b0);
    chk("rst_mid_memread", a_memread, 1'b0);
    chk("rst_mid_rt", a_rt, 5'd0);
    chk("rst_mid_cnt", a_cnt, 16'd0);
    chk("rst_mid_stall", a_stall, 1'b0);
    next(); rst_n = 1'b1;
    next(); next();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register for the pipelined MIPS datapath.
- Sits directly downstream of the main control decoder and register file. Captures the decoder's control bits plus the operand and field data, and presents them to the EX stage one cycle later.
- Contains the load-use hazard detector, which generates stall_o for PC/IF-ID and inserts a bubble into EX.
- Also supports a branch flush, an external hold, and a saturating bubble counter.

Parameters:
- DATA_W, 32, datapath width: PC+4, register operands, sign-extended immediate.
- REG_AW, 5, register-number width (rs/rt/rd).
- CNT_W, 16, bubble counter width; the counter saturates.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_op  in  6  opcode, used only for hazard rt-use decode
- id_regdst, id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memtowrite, id_branch  in  1 each  decoder control bits
- id_aluop  in  2  decoder ALUOp
- id_pc4, id_rdata1, id_rdata2, id_imm  in  DATA_W each  PC+4, rs data, rt data, sign-extended immediate
- id_rs, id_rt, id_rd  in  REG_AW each  register numbers
- id_funct  in  6  funct field
- flush_i  in  1  taken branch resolved downstream; kill the instruction entering EX
- hold_i  in  1  downstream freeze; all state holds
- ex_valid  out  1  EX holds a real instruction
- ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memtowrite, ex_branch  out  1 each  registered control bits
- ex_aluop  out  2  registered ALUOp
- ex_pc4, ex_rdata1, ex_rdata2, ex_imm  out  DATA_W each  registered data
- ex_rs, ex_rt, ex_rd  out  REG_AW each  registered register numbers
- ex_funct  out  6  registered funct
- stall_o  out  1  combinational; freeze PC and IF/ID this cycle
- bubble_cnt  out  CNT_W  count of hazard bubbles inserted

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-stall): every registered output and bubble_cnt go to 0. stall_o is then 0 because ex_memread=0.
- Latency: 1 cycle, ID inputs to ex_* outputs.
- Invalid inputs: when id_valid=0, all id_* control bits are treated as 0. This masks X from undecoded opcodes.
- rt-use decode: uses_rt=1 for id_op 000000 (R-type), 101011 (sw) and 000100 (beq). uses_rt=0 for 100011 (lw) and all other opcodes.
- Hazard: haz = ex_valid & ex_memread & (ex_rt!=0) & id_valid & ((ex_rt==id_rs) | (uses_rt & ex_rt==id_rt)).
- stall_o = haz & ~flush_i. Purely combinational, with no registered delay.
- Per-edge action, highest priority first:
  1. flush_i=1: load a bubble. bubble_cnt unchanged. Flush overrides hold_i and haz.
  2. hold_i=1: all registers keep their values; bubble_cnt unchanged. stall_o still reflects haz.
  3. haz=1: load a bubble; bubble_cnt += 1, saturating at all-ones.
  4. Otherwise: load all id_* fields; ex_valid = id_valid.
- Bubble definition: ex_valid, all control outputs, ex_aluop and all data/field outputs are loaded with 0.
- A load-use pair costs exactly 1 bubble. In the cycle after the bubble, ex_memread=0, so stall_o drops and the held ID instruction advances. Upstream logic keeps the ID inputs stable while stall_o=1.
- Hazards check EX only. Forwarding from MEM/WB is handled elsewhere.
- Register number 0 never produces a hazard.

Decomposition:
- Shared package mips_pkg:
  - opcode constants OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100
  - ALUOp constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
  - a packed control-bundle typedef holding the 7 control bits plus ALUOp
- One sub-module, load_use_detect: purely combinational. Computes uses_rt and haz from the ex_* and id_* fields; it is instantiated here and reusable by the IF/ID stage.

Test Plan:
- Reset mid-stall: lw x in EX with stall_o=1, pulse rst_n low between edges -> all ex_* outputs, bubble_cnt and stall_o read 0 immediately, before the next clock edge.
- Plain R-type: id_op=0, rdata1=0x11, rdata2=0x22, rd=3, aluop=10 -> the next cycle shows ex_regwrite=1, ex_regdst=1, ex_rdata1=0x11, ex_rd=3 and ex_valid=1; stall_o stays 0.
- Load-use: lw with rt=8 in EX, then add with rs=8 in ID -> stall_o=1. The next edge loads a bubble (ex_valid=0, ex_memread=0) and bubble_cnt=1. The following edge loads the add.
- No false hazard:
  - lw rt=8 in EX, lw with rt=8/rs=9 in ID -> stall_o=0, because lw does not use rt.
  - lw rt=0 in EX, add with rs=0 -> stall_o=0.
- Flush vs stall: load-use condition present and flush_i=1 on the same edge -> stall_o=0, a bubble is loaded, and bubble_cnt is unchanged.
- Hold and saturation:
  - With CNT_W=2, repeat the load-use sequence 5 times -> bubble_cnt=3.
  - hold_i=1 for 3 cycles -> all ex_* outputs frozen and bubble_cnt frozen.
